// File: rtl/pipe_ctrl_sequencer_pkg.sv
// pipe_ctrl_sequencer_pkg: opcodes, FSM state encoding and opcode-class helpers
package pipe_ctrl_sequencer_pkg;
    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        CTRL_WAIT = 2'd1,
        REDIRECT  = 2'd2
    } state_t;

    function automatic logic is_ctrl(input logic [5:0] op);
        return op inside {OP_BEQ, OP_BNE, OP_J};
    endfunction

    // rt is a source operand only for these; for lw/addi it is the destination
    function automatic logic reads_rt(input logic [5:0] op);
        return op inside {OP_R, OP_BEQ, OP_BNE, OP_SW};
    endfunction
endpackage

// File: rtl/pipe_ctrl_sequencer_if.sv
// pipe_ctrl_sequencer_if: pipeline-stage inputs and hazard/flush strobes of the sequencer
interface pipe_ctrl_sequencer_if #(parameter int CNT_W = 16);
    logic             id_valid;
    logic [5:0]       id_op;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             ex_valid;
    logic [5:0]       ex_op;
    logic [4:0]       ex_rt;
    logic             br_resolved;
    logic             br_taken;
    logic             pc_en;
    logic             pc_redirect;
    logic             ifid_en;
    logic             ifid_flush;
    logic             idex_bubble;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] stall_cnt;

    modport master (
        output id_valid, id_op, id_rs, id_rt, ex_valid, ex_op, ex_rt, br_resolved, br_taken,
        input  pc_en, pc_redirect, ifid_en, ifid_flush, idex_bubble, busy, err_timeout, stall_cnt
    );
    modport slave (
        input  id_valid, id_op, id_rs, id_rt, ex_valid, ex_op, ex_rt, br_resolved, br_taken,
        output pc_en, pc_redirect, ifid_en, ifid_flush, idex_bubble, busy, err_timeout, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl_sequencer_load_use_detect.sv
// load_use_detect: flags an ID instruction that reads the register a lw in EX is still loading
module load_use_detect
    import pipe_ctrl_sequencer_pkg::*;
(
    input  logic       ex_valid,
    input  logic [5:0] ex_op,
    input  logic [4:0] ex_rt,
    input  logic [5:0] id_op,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    output logic       hazard
);
    assign hazard = ex_valid & (ex_op == OP_LW) & (ex_rt != 5'd0) &
                    ((ex_rt == id_rs) | ((ex_rt == id_rt) & reads_rt(id_op)));
endmodule

// File: rtl/pipe_ctrl_sequencer.sv
// pipe_ctrl_sequencer: load-use stall and branch/jump fetch-hold FSM for the 5-stage pipeline
module pipe_ctrl_sequencer
    import pipe_ctrl_sequencer_pkg::*;
#(
    parameter int BR_LAT  = 2,
    parameter int JMP_LAT = 1,
    parameter int CNT_W   = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    pipe_ctrl_sequencer_if.slave bus
);
    localparam int TMO  = 4 * BR_LAT;
    localparam int TW   = $clog2(TMO + 1);
    localparam int WMAX = (BR_LAT > JMP_LAT) ? BR_LAT : JMP_LAT;
    localparam int WW   = $clog2(WMAX + 1);

    state_t           state;
    logic [WW-1:0]    wcnt;
    logic [TW-1:0]    tcnt;
    logic             is_jump;
    logic             taken;
    logic             err;
    logic [CNT_W-1:0] stall;
    logic             hazard;
    logic             run;
    logic             ctrl;
    logic             pc_en_i;

    load_use_detect u_lud (
        .ex_valid (bus.ex_valid),
        .ex_op    (bus.ex_op),
        .ex_rt    (bus.ex_rt),
        .id_op    (bus.id_op),
        .id_rs    (bus.id_rs),
        .id_rt    (bus.id_rt),
        .hazard   (hazard)
    );

    assign run     = state == RUN;
    assign ctrl    = run & bus.id_valid & is_ctrl(bus.id_op) & ~hazard;
    assign pc_en_i = run ? ~hazard & ~ctrl : state == REDIRECT;

    // Reset forces a safe flush/bubble pattern immediately, without waiting for a clock
    assign bus.pc_en       = rst_n & pc_en_i;
    assign bus.pc_redirect = rst_n & (state == REDIRECT) & (is_jump | taken);
    assign bus.ifid_en     = rst_n & run & ~hazard & ~ctrl;
    assign bus.ifid_flush  = ~rst_n | (run ? ctrl : 1'b1);
    assign bus.idex_bubble = ~rst_n | (run ? hazard : 1'b1);
    assign bus.busy        = rst_n & ~run;
    assign bus.err_timeout = err;
    assign bus.stall_cnt   = stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= RUN;
            wcnt    <= '0;
            tcnt    <= '0;
            is_jump <= 1'b0;
            taken   <= 1'b0;
            err     <= 1'b0;
            stall   <= '0;
        end else begin
            if (!pc_en_i && stall != '1)
                stall <= stall + CNT_W'(1);
            case (state)
                RUN: if (ctrl) begin
                    state   <= CTRL_WAIT;
                    is_jump <= bus.id_op == OP_J;
                    wcnt    <= (bus.id_op == OP_J) ? WW'(JMP_LAT - 1) : WW'(BR_LAT - 1);
                    tcnt    <= '0;
                    taken   <= 1'b0;
                end
                CTRL_WAIT: begin
                    wcnt <= wcnt - WW'(wcnt != '0);
                    if (is_jump) begin
                        if (wcnt == '0)
                            state <= REDIRECT;
                    end else if (bus.br_resolved) begin
                        state <= REDIRECT;
                        taken <= bus.br_taken;
                    end else begin
                        // tcnt counts unresolved wait cycles; the error fires once on the last allowed one
                        tcnt <= tcnt + TW'(tcnt != TW'(TMO));
                        if (tcnt == TW'(TMO - 1))
                            err <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end
endmodule

// File: tb/tb_pipe_ctrl_sequencer.sv
// tb_pipe_ctrl_sequencer: vector table, directed corner sequences and random run against a cycle-indexed model
module tb_pipe_ctrl_sequencer;
    localparam int BR_LAT  = 2;
    localparam int JMP_LAT = 1;
    localparam int CNT_W   = 8;
    localparam int SMAX    = 255;
    localparam logic [5:0] R = 6'b000000, BEQ = 6'b000100, BNE = 6'b000101, J = 6'b000010;
    localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, ADDI = 6'b001000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pipe_ctrl_sequencer_if #(.CNT_W(CNT_W)) bus();
    pipe_ctrl_sequencer #(.BR_LAT(BR_LAT), .JMP_LAT(JMP_LAT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int total = 0;
    int passed = 0;

    // model: absolute cycle numbers of the pending control transfer
    bit m_wait, m_jump, m_taken, m_err;
    int m_cyc, m_start, m_redir_at, m_stall;

    typedef struct {
        logic       ev;
        logic [5:0] eo;
        logic [4:0] ert;
        logic       iv;
        logic [5:0] io;
        logic [4:0] irs;
        logic [4:0] irt;
        logic [3:0] exp;
    } vec_t;
    vec_t tbl[13];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    function automatic logic [6:0] obs();
        return {bus.pc_en, bus.pc_redirect, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.busy, bus.err_timeout};
    endfunction

    task automatic drv(input logic iv, input logic [5:0] io, input logic [4:0] irs, input logic [4:0] irt,
                       input logic ev, input logic [5:0] eo, input logic [4:0] ert, input logic brr, input logic brt);
        bus.id_valid = iv; bus.id_op = io; bus.id_rs = irs; bus.id_rt = irt;
        bus.ex_valid = ev; bus.ex_op = eo; bus.ex_rt = ert;
        bus.br_resolved = brr; bus.br_taken = brt;
    endtask

    task automatic idle(input logic brr = 1'b0, input logic brt = 1'b0);
        drv(1'b0, R, 5'd0, 5'd0, 1'b0, R, 5'd0, brr, brt);
    endtask

    task automatic model_reset();
        m_wait = 0; m_jump = 0; m_taken = 0; m_err = 0; m_redir_at = -1; m_stall = 0;
    endtask

    task automatic expect_now(input string nm, input logic [6:0] e);
        #1 chk(nm, obs(), e);
    endtask

    task automatic step(input string nm);
        logic [6:0] e;
        bit lu, ct, redir;
        @(negedge clk);
        lu = bus.ex_valid && bus.ex_op == LW && bus.ex_rt != 0 &&
             (bus.ex_rt == bus.id_rs || (bus.ex_rt == bus.id_rt && bus.id_op inside {R, BEQ, BNE, SW}));
        ct = bus.id_valid && bus.id_op inside {BEQ, BNE, J};
        redir = m_cyc == m_redir_at;
        if (redir)       e = {1'b1, m_jump | m_taken, 5'b01110};
        else if (m_wait) e = 7'b0001110;
        else if (lu)     e = 7'b0000100;
        else if (ct)     e = 7'b0001000;
        else             e = 7'b1010000;
        e[0] = m_err;
        chk({nm, "_out"}, obs(), e);
        chk({nm, "_stall"}, 32'(bus.stall_cnt), m_stall);
        @(posedge clk);
        if (!e[6] && m_stall < SMAX) m_stall++;
        if (redir) m_redir_at = -1;
        else if (m_wait) begin
            if (m_jump) begin
                if (m_cyc == m_start + JMP_LAT) begin m_wait = 0; m_redir_at = m_cyc + 1; end
            end else if (bus.br_resolved) begin
                m_wait = 0; m_taken = bus.br_taken; m_redir_at = m_cyc + 1;
            end else if (m_cyc - m_start == 4 * BR_LAT) m_err = 1;
        end else if (!lu && ct) begin
            m_wait = 1; m_start = m_cyc; m_jump = bus.id_op == J; m_taken = 0;
        end
        m_cyc++;
        #1;
    endtask

    initial begin
        logic [5:0] ops[7];
        int s0;
        ops = '{R, BEQ, BNE, J, LW, SW, ADDI};
        //            ev  eo    ert   iv  io    irs   irt   {pc_en,ifid_en,flush,bubble}
        tbl[0]  = '{1, LW, 5'd5, 1, R,    5'd5, 5'd1, 4'b0001};
        tbl[1]  = '{1, LW, 5'd5, 1, R,    5'd1, 5'd5, 4'b0001};
        tbl[2]  = '{1, LW, 5'd0, 1, R,    5'd0, 5'd0, 4'b1100};
        tbl[3]  = '{1, LW, 5'd7, 1, ADDI, 5'd1, 5'd7, 4'b1100};
        tbl[4]  = '{1, LW, 5'd7, 1, SW,   5'd1, 5'd7, 4'b0001};
        tbl[5]  = '{1, LW, 5'd7, 1, LW,   5'd1, 5'd7, 4'b1100};
        tbl[6]  = '{0, LW, 5'd5, 1, R,    5'd5, 5'd1, 4'b1100};
        tbl[7]  = '{1, SW, 5'd5, 1, R,    5'd5, 5'd1, 4'b1100};
        tbl[8]  = '{0, R,  5'd0, 1, BEQ,  5'd1, 5'd2, 4'b0010};
        tbl[9]  = '{0, R,  5'd0, 0, J,    5'd0, 5'd0, 4'b1100};
        tbl[10] = '{1, LW, 5'd5, 1, BEQ,  5'd5, 5'd2, 4'b0001};
        tbl[11] = '{1, LW, 5'd5, 1, BNE,  5'd1, 5'd5, 4'b0001};
        tbl[12] = '{0, R,  5'd0, 1, J,    5'd0, 5'd0, 4'b0010};

        drv(1'b1, BEQ, 5'd1, 5'd2, 1'b1, LW, 5'd1, 1'b1, 1'b1);
        model_reset();
        m_cyc = 0;
        #2 chk("reset_out", obs(), 7'b0001100);
        chk("reset_stall", 32'(bus.stall_cnt), 0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();

        for (int i = 0; i < 13; i++) begin
            drv(tbl[i].ev, tbl[i].eo, tbl[i].ert, 1'b0, 6'd0, 5'd0, 5'd0, 1'b0, 1'b0);
            drv(tbl[i].iv, tbl[i].io, tbl[i].irs, tbl[i].irt, tbl[i].ev, tbl[i].eo, tbl[i].ert, 1'b0, 1'b0);
            #1 chk($sformatf("tbl%0d", i),
                   {bus.pc_en, bus.ifid_en, bus.ifid_flush, bus.idex_bubble, bus.pc_redirect, bus.busy},
                   {tbl[i].exp, 2'b00});
            idle();
            @(posedge clk);
            #1;
        end

        drv(1'b1, R, 5'd5, 5'd1, 1'b1, LW, 5'd5, 1'b0, 1'b0);
        expect_now("lu_stall", 7'b0000100);
        step("lu");
        idle();
        expect_now("lu_release", 7'b1010000);
        step("lu_after");

        drv(1'b1, BEQ, 5'd1, 5'd2, 1'b0, R, 5'd0, 1'b0, 1'b0);
        expect_now("beq_detect", 7'b0001000);
        step("beq_d");
        idle();
        expect_now("beq_wait1", 7'b0001110);
        step("beq_w1");
        idle(1'b1, 1'b1);
        expect_now("beq_wait2", 7'b0001110);
        step("beq_w2");
        idle();
        expect_now("beq_redir", 7'b1101110);
        step("beq_r");
        expect_now("beq_run", 7'b1010000);
        step("beq_run");

        s0 = m_stall;
        drv(1'b1, J, 5'd0, 5'd0, 1'b0, R, 5'd0, 1'b1, 1'b0);
        expect_now("j_detect", 7'b0001000);
        step("j_d");
        idle(1'b1, 1'b0);
        expect_now("j_wait", 7'b0001110);
        step("j_w");
        idle();
        expect_now("j_redir", 7'b1101110);
        chk("j_stall", 32'(bus.stall_cnt), s0 + 2);
        step("j_r");

        drv(1'b1, BNE, 5'd3, 5'd4, 1'b0, R, 5'd0, 1'b0, 1'b0);
        step("tmo_d");
        idle();
        for (int k = 1; k <= 4 * BR_LAT; k++) begin
            expect_now($sformatf("tmo_wait%0d", k), 7'b0001110);
            step("tmo_w");
        end
        expect_now("tmo_err", 7'b0001111);
        step("tmo_hold1");
        step("tmo_hold2");
        idle(1'b1, 1'b0);
        step("tmo_res");
        idle();
        expect_now("tmo_redir_nt", 7'b1001111);
        step("tmo_r");
        expect_now("tmo_run_err", 7'b1010001);

        drv(1'b1, BEQ, 5'd1, 5'd2, 1'b0, R, 5'd0, 1'b0, 1'b0);
        step("rst_d");
        idle();
        step("rst_w1");
        rst_n = 1'b0;
        idle(1'b1, 1'b1);
        expect_now("rst_forced", 7'b0001100);
        chk("rst_stall", 32'(bus.stall_cnt), 0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle();
        expect_now("rst_release", 7'b1010000);
        for (int k = 0; k < 4; k++) step("rst_after");

        for (int n = 0; n < 1500; n++) begin
            drv($urandom_range(0, 4) != 0, ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                $urandom_range(0, 2) != 0, ops[$urandom_range(0, 6)], 5'($urandom_range(0, 3)),
                $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
            step("rnd");
        end
        chk("stall_sat", 32'(bus.stall_cnt), SMAX);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
